dff_fifo: RTL and testbench

DFF_FIFO -- requirements
Module: dff_fifo

---
 rtl/dff_fifo_pkg.sv | 14 +
 rtl/dff_fifo_mem.sv | 36 +++
 rtl/dff_fifo.sv | 89 ++++++++
 tb/tb_dff_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dff_fifo_pkg.sv
// Shared defaults and occupancy-state type for the register-based FIFO.
package dff_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CW    = $clog2(DEF_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/dff_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
module fifo_mem
  import dff_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // storage array, cleared on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // combinational read port
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/dff_fifo.sv
// First-word fall-through FIFO: pointer, count and handshake logic around fifo_mem.
module dff_fifo
  import dff_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  occ_e          state_r;
  occ_e          state_nxt_s;
  logic          push_s;
  logic          pop_s;

  // handshakes only look at registered occupancy, never at the opposite side's inputs
  assign in_ready  = (state_r != ST_FULL);
  assign out_valid = (state_r != ST_EMPTY);
  assign count     = count_r;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // next count and occupancy state
  always_comb begin
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == CW'(0)) begin
      state_nxt_s = ST_EMPTY;
    end else if (count_nxt_s == CW'(DEPTH)) begin
      state_nxt_s = ST_FULL;
    end else begin
      state_nxt_s = ST_PARTIAL;
    end
  end

  // occupancy state and pointers; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_EMPTY;
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .raddr (rd_ptr_r),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_dff_fifo.sv
// Self-checking bench for dff_fifo: directed scenarios plus random traffic against a queue model.
module tb_dff_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] model[$];

  always #5 clock = ~clock;

  dff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // compare all outputs against the queue model
  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(model.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(model.size() != 0));
    check({tag, ".count_max"}, 32'(count <= CW'(DEPTH)), 32'd1);
    if (model.size() != 0) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(model[0]));
    end
  endtask

  // drive one cycle of stimulus, advance the model by the FIFO rules, then check
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
    int  sz;
    bit  do_push;
    bit  do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    sz      = model.size();
    do_push = v && (sz < DEPTH);
    do_pop  = r && (sz > 0);
    @(posedge clock);
    if (do_pop) begin
      void'(model.pop_front());
    end
    if (do_push) begin
      model.push_back(d);
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.count", 32'(count), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    reset = 1'b0;

    // idle with consumer ready
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, "idle");
      check("idle.out_data", 32'(out_data), 32'd0);
    end

    // fill, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0, "fill");
    check("full.count", 32'(count), 32'd4);
    check("full.in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, "overflow");
    check("overflow.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain.order", 32'(out_data), 32'(seq[i]));
      cycle(1'b0, 8'h00, 1'b1, "drain");
    end
    check("drain.count", 32'(count), 32'd0);

    // simultaneous push/pop at count=2, pointers wrap
    cycle(1'b1, 8'hE1, 1'b0, "pre2");
    cycle(1'b1, 8'hE2, 1'b0, "pre2");
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 8'(i), 1'b1, "pushpop");
      check("pushpop.count", 32'(count), 32'd2);
    end
    check("pushpop.head", 32'(out_data), 32'h09);

    // full with both sides active: pop only
    cycle(1'b1, 8'hB1, 1'b0, "refill");
    cycle(1'b1, 8'hB2, 1'b0, "refill");
    check("refill.count", 32'(count), 32'd4);
    cycle(1'b1, 8'hC0, 1'b1, "fullboth");
    check("fullboth.count", 32'(count), 32'd3);
    check("fullboth.in_ready", 32'(in_ready), 32'd1);

    // asynchronous reset at count=3, between edges
    #3;
    reset = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    check("arst.out_data", 32'(out_data), 32'd0);
    model.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cycle(1'b1, 8'hA5, 1'b0, "postrst");
    check("postrst.out_data", 32'(out_data), 32'hA5);
    check("postrst.count", 32'(count), 32'd1);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
